// File: rtl/sd_server_pkg.sv
// Shared constants and FSM state encodings for sd_sector_server.
package sd_server_pkg;
  localparam int SECTOR_BYTES = 512;
  localparam int BYTE_W = 9;

  typedef logic [3:0] state_t;

  localparam state_t IDLE    = 4'd0;
  localparam state_t ACCEPT  = 4'd1;
  localparam state_t RD_REQ  = 4'd2;
  localparam state_t RD_WAIT = 4'd3;
  localparam state_t RD_STB  = 4'd4;
  localparam state_t WR_ADDR = 4'd5;
  localparam state_t WR_LAT  = 4'd6;
  localparam state_t WR_REQ  = 4'd7;
  localparam state_t DONE    = 4'd8;
endpackage

// File: rtl/sd_sector_server.sv
// Standalone sector server: answers sd_rd/sd_wr from a byte-wide backing memory.
// Optional SD_SIZE_CHECK_EN: per-drive image size check, out-of-range sectors are not touched.
module sd_sector_server
  import sd_server_pkg::*;
#(
  parameter int DRIVES = 2,
  parameter int SECT_W = 11,
  localparam int DRV_W = (DRIVES > 1) ? $clog2(DRIVES) : 1,
  localparam int ADDR_W = DRV_W + SECT_W + BYTE_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [DRIVES-1:0] img_mounted,
  input  logic [63:0]       img_size,
  input  logic [31:0]       sd_lba,
  input  logic [DRIVES-1:0] sd_rd,
  input  logic [DRIVES-1:0] sd_wr,
  output logic [DRIVES-1:0] sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic              busy
);

  state_t state;
  state_t state_nx;

  logic [DRV_W-1:0]  drv;
  logic [SECT_W-1:0] lba;
  logic              dir_wr;
  logic              oor;
  logic [BYTE_W-1:0] n;
  logic [7:0]        rdata;
  logic [DRIVES-1:0] armed;

  logic [DRIVES-1:0] req;
  logic [DRIVES-1:0] elig;
  logic [DRIVES-1:0] win_oh;
  logic              hit;
  logic [DRV_W-1:0]  win;
  logic              win_wr;
  logic              win_oor;
  logic              last;
  logic              unused;

  // Lowest index wins; read beats write on the same drive.
  always_comb begin
    req = sd_rd | sd_wr;
    elig = req & armed;
    hit = 1'b0;
    win = '0;
    win_wr = 1'b0;
    for (int i = DRIVES - 1; i >= 0; i--) begin
      if (elig[i]) begin
        hit = 1'b1;
        win = DRV_W'(i);
        win_wr = !sd_rd[i];
      end
    end
  end

  assign win_oh = DRIVES'(1) << win;

`ifdef SD_SIZE_CHECK_EN
  logic [SECT_W:0] size [DRIVES];
  logic [SECT_W:0] msize;

  assign msize = (img_size[63:9] > 55'(1 << SECT_W))
               ? {1'b1, {SECT_W{1'b0}}}
               : img_size[9 +: SECT_W + 1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DRIVES; i++) size[i] <= '0;
    end else begin
      for (int i = 0; i < DRIVES; i++)
        if (img_mounted[i]) size[i] <= msize;
    end
  end

  // Old size is read here even when a mount lands on the same edge.
  assign win_oor = sd_lba >= 32'(size[win]);
  assign unused = ^img_size[8:0];
`else
  assign win_oor = 1'b0;
  assign unused = ^{sd_lba[31:SECT_W], img_size, img_mounted};
`endif

  assign last = n == BYTE_W'(SECTOR_BYTES - 1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hit) state_nx = ACCEPT;
      ACCEPT:  state_nx = dir_wr ? WR_ADDR : RD_REQ;
      RD_REQ:  state_nx = (oor || mem_ready) ? RD_STB : RD_WAIT;
      RD_WAIT: if (mem_ready) state_nx = RD_STB;
      RD_STB:  state_nx = last ? DONE : RD_REQ;
      WR_ADDR: state_nx = WR_LAT;
      WR_LAT:  state_nx = WR_REQ;
      WR_REQ:  if (oor || mem_ready) state_nx = last ? DONE : WR_ADDR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      drv <= '0;
      lba <= '0;
      dir_wr <= 1'b0;
      oor <= 1'b0;
      n <= '0;
      rdata <= '0;
      mem_din <= '0;
      armed <= '1;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          // A drive re-arms only once its request level is seen low.
          armed <= (armed | ~req) & ~(hit ? win_oh : '0);
          if (hit) begin
            drv <= win;
            lba <= sd_lba[SECT_W-1:0];
            dir_wr <= win_wr;
            oor <= win_oor;
            n <= '0;
          end
        end
        RD_REQ, RD_WAIT: begin
          if (oor) rdata <= '0;
          else if (mem_ready) rdata <= mem_dout;
        end
        RD_STB: n <= n + 1'b1;
        WR_LAT: mem_din <= sd_buff_din;
        WR_REQ: if (oor || mem_ready) n <= n + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = state != IDLE;
  assign sd_ack = (busy && state != DONE) ? (DRIVES'(1) << drv) : '0;
  assign mem_rd = (state == RD_REQ || state == RD_WAIT) && !oor;
  assign mem_wr = state == WR_REQ && !oor;
  assign mem_addr = {drv, lba, n};
  assign sd_buff_addr = n;
  assign sd_buff_dout = rdata;
  assign sd_buff_wr = state == RD_STB;

endmodule
